window_feeder: RTL and testbench

WINDOW_FEEDER -- requirements
Module: window_feeder

---
 rtl/window_feeder.sv | 125 ++++++++++++
 tb/tb_window_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_feeder.sv
// Streams a row-major 8-bit image and emits every valid 3x3 window (stride 1 or 2),
// registered one cycle after the pixel that completes it.
module window_feeder #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pix_in,
   input  logic        pix_en,
   input  logic        stride2,
   output logic [71:0] win_out,
   output logic        win_en,
   output logic        frame_done,
   output logic [1:0]  dbg_state_o
);
   // Handshake: pix_en is a valid-only strobe with no backpressure; every cycle with
   // pix_en=1 and reset=0 consumes pix_in. win_en is a one-cycle valid with no ready.
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int LB = IMG_W - 1;

   localparam logic [CW-1:0] COL_TWO     = CW'(2);
   localparam logic [RW-1:0] ROW_ONE     = RW'(1);
   localparam logic [RW-1:0] ROW_TWO     = RW'(2);
   localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);
   // Final window corner under stride 2 is the last position with (r-2),(c-2) even.
   localparam logic [CW-1:0] COL_LAST_S2 = CW'(IMG_W - 1 - ((IMG_W - 3) % 2));
   localparam logic [RW-1:0] ROW_LAST_S2 = RW'(IMG_H - 1 - ((IMG_H - 3) % 2));

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          stride_q, stride_d;
   logic [71:0]   win_out_q;
   logic          win_en_q, done_q;

   logic [7:0]  lb1_q [LB];
   logic [7:0]  lb2_q [LB];
   logic [47:0] cols_q;
   logic [47:0] cols_d;
   logic [71:0] win_d;

   logic accept, elig, last_pix, last_elig;

   assign accept   = pix_en & ~reset;
   assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign elig     = (row_q >= ROW_TWO) && (col_q >= COL_TWO) &&
                     (!stride_q || (!row_q[0] && !col_q[0]));
   assign last_elig = elig && (stride_q ? ((row_q == ROW_LAST_S2) && (col_q == COL_LAST_S2))
                                        : last_pix);

   // cols_q keeps the two most recent window columns; the third comes from the
   // line-buffer taps plus the incoming pixel, completing the 3x3 window.
   assign win_d  = {cols_q[47:32], lb2_q[LB-1], cols_q[31:16], lb1_q[LB-1], cols_q[15:0], pix_in};
   assign cols_d = {cols_q[39:32], lb2_q[LB-1], cols_q[23:16], lb1_q[LB-1], cols_q[7:0], pix_in};

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      state_d  = state_q;
      stride_d = stride_q;
      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_FILL;
               stride_d = stride2;
            end
            ST_FILL:   if (row_q == ROW_ONE && col_q == COL_LAST) state_d = ST_ACTIVE;
            ST_ACTIVE: if (last_pix) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         stride_q  <= 1'b0;
         win_out_q <= '0;
         win_en_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         stride_q <= stride_d;
         win_en_q <= accept & elig;
         done_q   <= accept & last_elig;
         if (accept && elig) win_out_q <= win_d;
      end
   end

   // Line buffers carry no reset: eligibility only opens once rows r-1, r-2 are refilled.
   always_ff @(posedge clk) begin
      if (accept) begin
         cols_q   <= cols_d;
         lb1_q[0] <= cols_q[7:0];
         lb2_q[0] <= cols_q[23:16];
         for (int i = 1; i < LB; i++) begin
            lb1_q[i] <= lb1_q[i-1];
            lb2_q[i] <= lb2_q[i-1];
         end
      end
   end

   assign win_out     = win_out_q;
   assign win_en      = win_en_q;
   assign frame_done  = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_window_feeder.sv
// Randomized bench for window_feeder: a frame-array reference model predicts every
// window, pulse timing, frame_done and FSM phase; directed frames pin known values.
module tb_window_feeder;
   localparam int W = 8;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic        stride2;
   logic [7:0]  pix_in;
   logic [71:0] win_out;
   logic        win_en;
   logic        frame_done;
   logic [1:0]  dbg_state;

   window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_in      (pix_in),
      .pix_en      (pix_en),
      .stride2     (stride2),
      .win_out     (win_out),
      .win_en      (win_en),
      .frame_done  (frame_done),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  img [H][W];
   int          m_r = 0;
   int          m_c = 0;
   bit          m_s = 1'b0;
   logic [71:0] exp_q[$];
   logic [71:0] cur_win = '0;
   bit          exp_en = 1'b0;
   bit          exp_fd = 1'b0;
   int          exp_state = 0;

   function automatic bit eligible(input int r, input int c, input bit s);
      if (r < 2 || c < 2) return 1'b0;
      if (s) return ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
      return 1'b1;
   endfunction

   function automatic bit more_after(input int r, input int c, input bit s);
      for (int k = r * W + c + 1; k < W * H; k++)
         if (eligible(k / W, k % W, s)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [71:0] window_at(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w = {w[63:0], img[r-2+dr][c-2+dc]};
      return w;
   endfunction

   task automatic model_step();
      exp_en = 1'b0;
      exp_fd = 1'b0;
      if (reset) begin
         m_r = 0; m_c = 0; m_s = 1'b0; cur_win = '0;
         exp_q.delete();
      end else if (pix_en) begin
         if (m_r == 0 && m_c == 0) m_s = stride2;
         img[m_r][m_c] = pix_in;
         if (eligible(m_r, m_c, m_s)) begin
            cur_win = window_at(m_r, m_c);
            exp_q.push_back(cur_win);
            exp_en = 1'b1;
            exp_fd = !more_after(m_r, m_c, m_s);
         end
         m_c++;
         if (m_c == W) begin
            m_c = 0;
            m_r++;
            if (m_r == H) m_r = 0;
         end
      end
      exp_state = (m_r == 0 && m_c == 0) ? 0 : ((m_r < 2) ? 1 : 2);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- scoreboard / monitor ----------------
   bit          mon_on = 1'b0;
   int          pulse_cnt = 0;
   int          fd_cnt = 0;
   bit          first_seen = 1'b0;
   logic [71:0] first_win = '0;
   logic [71:0] last_win = '0;

   task automatic monitor_step();
      logic [71:0] e;
      check_eq("win_en", 72'(win_en), 72'(exp_en));
      check_eq("frame_done", 72'(frame_done), 72'(exp_fd));
      check_eq("state", 72'(dbg_state), 72'(exp_state));
      if (frame_done) fd_cnt++;
      if (win_en) begin
         pulse_cnt++;
         check_eq("win_q_level", 72'(exp_q.size()), 72'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("win_out", win_out, e);
         end
         if (!first_seen) begin
            first_seen = 1'b1;
            first_win  = win_out;
         end
         last_win = win_out;
      end else begin
         check_eq("win_hold", win_out, cur_win);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (mon_on) monitor_step();
   end

   // ---------------- drivers ----------------
   task automatic drive(input logic rst, input logic en, input logic [7:0] d, input logic s);
      @(posedge clk);
      #1;
      reset = rst; pix_en = en; pix_in = d; stride2 = s;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
   endtask

   task automatic send_pix(input logic [7:0] v, input logic s, input int gap);
      drive(1'b0, 1'b1, v, s);
      idle(gap);
   endtask

   // s_rest: 0/1 holds stride2 at that value after pixel 0, 2 randomizes it.
   task automatic send_frame(input int base, input bit rnd_data, input logic s_first,
                             input int s_rest, input int gap_lo, input int gap_hi);
      for (int k = 0; k < W * H; k++) begin
         logic [7:0] v;
         logic       s;
         v = rnd_data ? 8'($urandom) : 8'(base + k);
         if (k == 0)           s = s_first;
         else if (s_rest == 2) s = 1'($urandom);
         else                  s = 1'(s_rest);
         send_pix(v, s, int'($urandom_range(gap_hi, gap_lo)));
      end
   endtask

   task automatic start_test();
      pulse_cnt = 0; fd_cnt = 0; first_seen = 1'b0; first_win = '0; last_win = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_exp;
      bit sf;
      reset = 1'b1; pix_en = 1'b0; pix_in = '0; stride2 = 1'b0;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      @(negedge clk);
      check_eq("rst_win_out", win_out, 72'h0);
      check_eq("rst_win_en", 72'(win_en), 72'd0);
      check_eq("rst_frame_done", 72'(frame_done), 72'd0);
      check_eq("rst_state", 72'(dbg_state), 72'd0);
      drive(1'b1, 1'b1, 8'h55, 1'b1);

      // stride 1, gapless ramp
      start_test();
      send_frame(0, 1'b0, 1'b0, 2, 0, 0);
      idle(3);
      check_eq("s1_pulses", 72'(pulse_cnt), 72'd36);
      check_eq("s1_done", 72'(fd_cnt), 72'd1);
      check_eq("s1_first", first_win, 72'h000102_08090A_101112);
      check_eq("s1_last", last_win, 72'h2D2E2F_353637_3D3E3F);

      // stride 2
      start_test();
      send_frame(0, 1'b0, 1'b1, 2, 0, 0);
      idle(3);
      check_eq("s2_pulses", 72'(pulse_cnt), 72'd9);
      check_eq("s2_done", 72'(fd_cnt), 72'd1);
      check_eq("s2_first", first_win, 72'h000102_08090A_101112);
      check_eq("s2_last", last_win, 72'h242526_2C2D2E_343536);

      // two idle cycles after every pixel
      start_test();
      send_frame(0, 1'b0, 1'b0, 2, 2, 2);
      idle(3);
      check_eq("gap_pulses", 72'(pulse_cnt), 72'd36);
      check_eq("gap_first", first_win, 72'h000102_08090A_101112);
      check_eq("gap_last", last_win, 72'h2D2E2F_353637_3D3E3F);

      // reset after pixel 30, colliding with a pix_en
      start_test();
      for (int k = 0; k <= 30; k++) send_pix(8'(k), 1'b0, 0);
      drive(1'b1, 1'b1, 8'hEE, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      check_eq("rst_mid_pre_pulses", 72'(pulse_cnt), 72'd11);
      start_test();
      send_frame(8'h40, 1'b0, 1'b0, 2, 0, 0);
      idle(3);
      check_eq("rst_mid_first", first_win, 72'h404142_48494A_505152);
      check_eq("rst_mid_pulses", 72'(pulse_cnt), 72'd36);

      // back-to-back random frames
      start_test();
      send_frame(0, 1'b1, 1'b0, 2, 0, 0);
      send_frame(0, 1'b1, 1'b0, 2, 0, 0);
      idle(3);
      check_eq("b2b_pulses", 72'(pulse_cnt), 72'd72);
      check_eq("b2b_done", 72'(fd_cnt), 72'd2);

      // stride2 raised mid-frame only applies to the following frame
      start_test();
      send_frame(0, 1'b1, 1'b0, 1, 0, 0);
      idle(3);
      check_eq("tog_cur_pulses", 72'(pulse_cnt), 72'd36);
      start_test();
      send_frame(0, 1'b1, 1'b1, 1, 0, 0);
      idle(3);
      check_eq("tog_next_pulses", 72'(pulse_cnt), 72'd9);

      // random frames, random stride, random gaps
      start_test();
      n_exp = 0;
      repeat (4) begin
         sf = 1'($urandom);
         n_exp += sf ? 9 : 36;
         send_frame(0, 1'b1, sf, 2, 0, 2);
      end
      idle(3);
      check_eq("rnd_pulses", 72'(pulse_cnt), 72'(n_exp));
      check_eq("rnd_done", 72'(fd_cnt), 72'd4);
      check_eq("q_drained", 72'(exp_q.size()), 72'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
